// File: rtl/kronos_obi_periph_responder_pkg.sv
// Shared types and constants for the kronos external-peripheral OBI responder.
package kronos_obi_periph_responder_pkg;

    localparam logic [31:0] kronos_PERIPH_START_ADDRESS = 32'h2000_0000;
    localparam logic [31:0] kronos_PERIPH_SIZE          = 32'h0001_0000;
    localparam logic [31:0] KRONOS_ERR_RDATA            = 32'hBADC_AB1E;

    localparam int unsigned TMO_W = 16;
    localparam int unsigned ECW   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } kronos_resp_state_e;

endpackage

// File: rtl/kronos_obi_periph_responder_if.sv
// OBI slave port plus the downstream register-bank port of the responder.
interface kronos_obi_periph_responder_if #(
    parameter int unsigned AW = 12
);
    logic          req_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          resp_err_o;
    logic          reg_valid_o;
    logic          reg_we_o;
    logic [3:0]    reg_be_o;
    logic [AW-1:0] reg_addr_o;
    logic [31:0]   reg_wdata_o;
    logic          reg_ready_i;
    logic [31:0]   reg_rdata_i;
    logic          reg_error_i;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        input  reg_ready_i, reg_rdata_i, reg_error_i,
        output gnt_o, rvalid_o, rdata_o, resp_err_o,
        output reg_valid_o, reg_we_o, reg_be_o, reg_addr_o, reg_wdata_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        output reg_ready_i, reg_rdata_i, reg_error_i,
        input  gnt_o, rvalid_o, rdata_o, resp_err_o,
        input  reg_valid_o, reg_we_o, reg_be_o, reg_addr_o, reg_wdata_o
    );
endinterface

// File: rtl/kronos_obi_periph_responder.sv
// OBI target for the kronos peripheral window: decodes the window, forwards hits to the
// register bank with a timeout, and answers misses/timeouts/downstream errors with an error.
module kronos_obi_periph_responder
    import kronos_obi_periph_responder_pkg::*;
#(
    parameter logic [31:0] START_ADDR     = kronos_PERIPH_START_ADDRESS,
    parameter logic [31:0] WIN_SIZE       = kronos_PERIPH_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = KRONOS_ERR_RDATA
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    kronos_obi_periph_responder_if.slave    bus,
    output logic [ECW-1:0]                  err_cnt_o
);

    localparam int unsigned      AW       = $clog2(WIN_SIZE);
    localparam logic [32:0]      WIN_LO   = {1'b0, START_ADDR};
    localparam logic [32:0]      WIN_HI   = 33'(START_ADDR) + 33'(WIN_SIZE);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ECW-1:0]   ERR_MAX  = '1;

    kronos_resp_state_e state_q, state_d;

    logic             rvalid_q,    rvalid_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             resp_err_q,  resp_err_d;
    logic             reg_valid_q, reg_valid_d;
    logic             reg_we_q,    reg_we_d;
    logic [3:0]       reg_be_q,    reg_be_d;
    logic [AW-1:0]    reg_addr_q,  reg_addr_d;
    logic [31:0]      reg_wdata_q, reg_wdata_d;
    logic             we_q,        we_d;
    logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic [ECW-1:0]   err_cnt_q,   err_cnt_d;
    logic             hit;
    logic             err_evt;

    // 33-bit compare so a window ending at 4 GiB does not wrap
    assign hit = ({1'b0, bus.addr_i} >= WIN_LO) && ({1'b0, bus.addr_i} < WIN_HI);

    // Same-cycle grant, only in IDLE and never during reset
    assign bus.gnt_o = (state_q == IDLE) && bus.req_i && !rst_i;

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            resp_err_q  <= 1'b0;
            reg_valid_q <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_be_q    <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            we_q        <= 1'b0;
            tmo_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            resp_err_q  <= resp_err_d;
            reg_valid_q <= reg_valid_d;
            reg_we_q    <= reg_we_d;
            reg_be_q    <= reg_be_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            we_q        <= we_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next state and next registered-output values
    always_comb begin
        state_d     = state_q;
        rvalid_d    = 1'b0;
        rdata_d     = '0;
        resp_err_d  = 1'b0;
        reg_valid_d = reg_valid_q;
        reg_we_d    = reg_we_q;
        reg_be_d    = reg_be_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_d        = we_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_evt     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d = bus.we_i;
                    if (hit) begin
                        state_d     = ISSUE;
                        reg_valid_d = 1'b1;
                        reg_we_d    = bus.we_i;
                        reg_be_d    = bus.be_i;
                        reg_addr_d  = AW'(bus.addr_i - START_ADDR);
                        reg_wdata_d = bus.wdata_i;
                        tmo_cnt_d   = '0;
                    end else begin
                        state_d    = RESP;
                        rvalid_d   = 1'b1;
                        resp_err_d = 1'b1;
                        rdata_d    = bus.we_i ? 32'h0 : ERR_RDATA;
                        err_evt    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Ready in the expiry cycle still completes normally
                if (bus.reg_ready_i) begin
                    state_d     = RESP;
                    reg_valid_d = 1'b0;
                    rvalid_d    = 1'b1;
                    tmo_cnt_d   = '0;
                    if (bus.reg_error_i) begin
                        resp_err_d = 1'b1;
                        rdata_d    = we_q ? 32'h0 : ERR_RDATA;
                        err_evt    = 1'b1;
                    end else begin
                        rdata_d = we_q ? 32'h0 : bus.reg_rdata_i;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = RESP;
                    reg_valid_d = 1'b0;
                    rvalid_d    = 1'b1;
                    resp_err_d  = 1'b1;
                    rdata_d     = we_q ? 32'h0 : ERR_RDATA;
                    tmo_cnt_d   = '0;
                    err_evt     = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_evt && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ECW'(1);
        end
    end

    assign bus.rvalid_o    = rvalid_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.resp_err_o  = resp_err_q;
    assign bus.reg_valid_o = reg_valid_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.reg_be_o    = reg_be_q;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_kronos_obi_periph_responder.sv
// Directed bench for kronos_obi_periph_responder with a 4 KiB window at 0x0001_0000.
module tb_kronos_obi_periph_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_cnt;
    int         nvec = 0;
    int         nmis = 0;
    logic       saw_valid;

    kronos_obi_periph_responder_if #(.AW(12)) bus ();

    kronos_obi_periph_responder #(
        .START_ADDR     (32'h0001_0000),
        .WIN_SIZE       (32'h0000_1000),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hBADC_AB1E)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus.slave),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.be_i    = be;
        #1;
    endtask

    task automatic idle_bus();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        bus.be_i    = '0;
    endtask

    initial begin
        idle_bus();
        bus.reg_ready_i = 1'b0;
        bus.reg_rdata_i = '0;
        bus.reg_error_i = 1'b0;

        // Reset, with a request pending to show grant is held low
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0001_0000;
        tick();
        tick();
        chk("rst_gnt",      32'(bus.gnt_o), 32'h0);
        chk("rst_rvalid",   32'(bus.rvalid_o), 32'h0);
        chk("rst_rdata",    bus.rdata_o, 32'h0);
        chk("rst_reg_valid",32'(bus.reg_valid_o), 32'h0);
        chk("rst_reg_addr", 32'(bus.reg_addr_o), 32'h0);
        chk("rst_err_cnt",  32'(err_cnt), 32'h0);
        idle_bus();
        rst = 1'b0;
        tick();

        // Read hit, zero wait
        req(1'b0, 32'h0001_0040, 32'h0, 4'hF);
        chk("rd_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        idle_bus();
        bus.reg_ready_i = 1'b1;
        bus.reg_rdata_i = 32'hCAFE_0001;
        #1;
        chk("rd_reg_valid", 32'(bus.reg_valid_o), 32'h1);
        chk("rd_reg_addr",  32'(bus.reg_addr_o), 32'h040);
        chk("rd_gnt_busy",  32'(bus.gnt_o), 32'h0);
        tick();
        bus.reg_ready_i = 1'b0;
        chk("rd_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("rd_rdata",  bus.rdata_o, 32'hCAFE_0001);
        chk("rd_err",    32'(bus.resp_err_o), 32'h0);
        chk("rd_errcnt", 32'(err_cnt), 32'h0);
        chk("rd_reg_valid_drop", 32'(bus.reg_valid_o), 32'h0);
        tick();
        chk("rd_rvalid_1cyc", 32'(bus.rvalid_o), 32'h0);
        chk("rd_rdata_clr",   bus.rdata_o, 32'h0);

        // Write hit at top of window, 3-cycle wait
        req(1'b1, 32'h0001_0FFC, 32'h1234_5678, 4'b0011);
        chk("wr_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            chk("wr_reg_valid", 32'(bus.reg_valid_o), 32'h1);
            chk("wr_reg_addr",  32'(bus.reg_addr_o), 32'hFFC);
            chk("wr_reg_we",    32'(bus.reg_we_o), 32'h1);
            chk("wr_reg_be",    32'(bus.reg_be_o), 32'h3);
            chk("wr_reg_wdata", bus.reg_wdata_o, 32'h1234_5678);
            if (i == 2) bus.reg_ready_i = 1'b1;
            bus.reg_rdata_i = 32'hFFFF_FFFF;
            tick();
        end
        bus.reg_ready_i = 1'b0;
        chk("wr_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("wr_rdata",  bus.rdata_o, 32'h0);
        chk("wr_err",    32'(bus.resp_err_o), 32'h0);
        tick();

        // Boundary misses: one past the end, one below the base
        req(1'b0, 32'h0001_1000, 32'h0, 4'hF);
        chk("miss_hi_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        idle_bus();
        chk("miss_hi_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("miss_hi_rdata",  bus.rdata_o, 32'hBADC_AB1E);
        chk("miss_hi_err",    32'(bus.resp_err_o), 32'h1);
        chk("miss_hi_regv",   32'(bus.reg_valid_o), 32'h0);
        tick();
        req(1'b0, 32'h0000_FFFC, 32'h0, 4'hF);
        tick();
        idle_bus();
        chk("miss_lo_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("miss_lo_rdata",  bus.rdata_o, 32'hBADC_AB1E);
        chk("miss_lo_err",    32'(bus.resp_err_o), 32'h1);
        chk("miss_lo_regv",   32'(bus.reg_valid_o), 32'h0);
        chk("miss_errcnt",    32'(err_cnt), 32'h2);
        tick();

        // Timeout: ready never comes
        req(1'b0, 32'h0001_0100, 32'h0, 4'hF);
        tick();
        idle_bus();
        for (int i = 0; i < 8; i++) begin
            chk("tmo_regv_hold", 32'(bus.reg_valid_o), 32'h1);
            tick();
        end
        chk("tmo_regv_drop", 32'(bus.reg_valid_o), 32'h0);
        chk("tmo_rvalid",    32'(bus.rvalid_o), 32'h1);
        chk("tmo_rdata",     bus.rdata_o, 32'hBADC_AB1E);
        chk("tmo_err",       32'(bus.resp_err_o), 32'h1);
        chk("tmo_errcnt",    32'(err_cnt), 32'h3);
        tick();

        // Ready arriving exactly in the expiry cycle wins
        req(1'b0, 32'h0001_0104, 32'h0, 4'hF);
        tick();
        idle_bus();
        for (int i = 0; i < 8; i++) begin
            chk("tmo2_regv_hold", 32'(bus.reg_valid_o), 32'h1);
            if (i == 7) begin
                bus.reg_ready_i = 1'b1;
                bus.reg_rdata_i = 32'h5555_AAAA;
            end
            tick();
        end
        bus.reg_ready_i = 1'b0;
        chk("tmo2_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("tmo2_rdata",  bus.rdata_o, 32'h5555_AAAA);
        chk("tmo2_err",    32'(bus.resp_err_o), 32'h0);
        chk("tmo2_errcnt", 32'(err_cnt), 32'h3);
        tick();

        // Downstream error on a read
        req(1'b0, 32'h0001_0200, 32'h0, 4'hF);
        tick();
        idle_bus();
        bus.reg_ready_i = 1'b1;
        bus.reg_error_i = 1'b1;
        bus.reg_rdata_i = 32'h1111_2222;
        tick();
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;
        chk("derr_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("derr_err",    32'(bus.resp_err_o), 32'h1);
        chk("derr_rdata",  bus.rdata_o, 32'hBADC_AB1E);
        chk("derr_errcnt", 32'(err_cnt), 32'h4);
        tick();

        // 300 back-to-back misses saturate the error counter
        saw_valid = 1'b0;
        req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
        for (int i = 0; i < 300; i++) begin
            tick();
            saw_valid = saw_valid | bus.reg_valid_o;
            tick();
            saw_valid = saw_valid | bus.reg_valid_o;
            if (i == 250) chk("sat_errcnt_251", 32'(err_cnt), 32'hFF);
        end
        idle_bus();
        chk("sat_errcnt", 32'(err_cnt), 32'hFF);
        chk("sat_no_regv", 32'(saw_valid), 32'h0);
        tick();

        // Reset while a hit is in ISSUE
        req(1'b0, 32'h0001_0300, 32'h0, 4'hF);
        tick();
        idle_bus();
        chk("mid_regv", 32'(bus.reg_valid_o), 32'h1);
        rst = 1'b1;
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0001_0000;
        tick();
        chk("mid_rst_gnt",    32'(bus.gnt_o), 32'h0);
        chk("mid_rst_regv",   32'(bus.reg_valid_o), 32'h0);
        chk("mid_rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("mid_rst_addr",   32'(bus.reg_addr_o), 32'h0);
        chk("mid_rst_errcnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        idle_bus();
        tick();
        chk("mid_post_rvalid", 32'(bus.rvalid_o), 32'h0);

        // Fresh request at the window base completes normally
        req(1'b0, 32'h0001_0000, 32'h0, 4'hF);
        chk("post_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        idle_bus();
        bus.reg_ready_i = 1'b1;
        bus.reg_rdata_i = 32'h0BAD_F00D;
        #1;
        chk("post_regv", 32'(bus.reg_valid_o), 32'h1);
        chk("post_addr", 32'(bus.reg_addr_o), 32'h000);
        tick();
        bus.reg_ready_i = 1'b0;
        chk("post_rvalid", 32'(bus.rvalid_o), 32'h1);
        chk("post_rdata",  bus.rdata_o, 32'h0BAD_F00D);
        chk("post_err",    32'(bus.resp_err_o), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/kronos_obi_periph_responder.md
Name: kronos_obi_periph_responder

Overview:
- OBI slave-side responder for the kronos external-peripheral window: the target end of the address decode done by the external peripheral crossbar rules.
- Accepts single OBI transactions and checks the address against its window.
- In-window accesses go to a variable-latency register-bank interface inside kronos. Out-of-window accesses and downstream timeouts get an error response.
- Sits between the X-HEEP external peripheral port and the kronos control/status register bank.

Parameters:
- START_ADDR, kronos_x_heep_pkg::kronos_PERIPH_START_ADDRESS: window base (byte address).
- WIN_SIZE, kronos_x_heep_pkg::kronos_PERIPH_SIZE: window size in bytes; must be a power of two and ≥ 4.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for reg_ready_i; range 1..65535.
- ERR_RDATA, 32'hBADC_AB1E: read data returned on any error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  OBI request
- we_i  in  1  OBI write enable
- be_i  in  4  OBI byte enables
- addr_i  in  32  OBI byte address
- wdata_i  in  32  OBI write data
- gnt_o  out  1  OBI grant
- rvalid_o  out  1  OBI response valid
- rdata_o  out  32  OBI read data
- resp_err_o  out  1  error flag, qualified by rvalid_o
- reg_valid_o  out  1  downstream request valid
- reg_we_o  out  1  downstream write enable
- reg_be_o  out  4  downstream byte enables
- reg_addr_o  out  AW=$clog2(WIN_SIZE)  window offset
- reg_wdata_o  out  32  downstream write data
- reg_ready_i  in  1  downstream accept/complete
- reg_rdata_i  in  32  downstream read data, valid with reg_ready_i
- reg_error_i  in  1  downstream error, valid with reg_ready_i
- err_cnt_o  out  8  saturating error counter

Behaviour:
- Reset: one clock, synchronous active-high reset on rst_i. While rst_i=1 and after it: state IDLE, gnt_o=0 (forced low during reset), rvalid_o=0, rdata_o=0, resp_err_o=0, reg_valid_o=0, reg_* payload=0, timeout counter=0, err_cnt_o=0.
- States:
  - IDLE: gnt_o = req_i (combinational, same-cycle grant). On req_i, latch we/be/addr/wdata and compute hit = (addr_i >= START_ADDR) && (addr_i < START_ADDR+WIN_SIZE). Compare unsigned; the end address is exclusive. The addition is done in 33 bits so a window at the top of the address space does not wrap.
    - hit=1 → ISSUE.
    - hit=0 → RESP with error.
  - ISSUE: reg_valid_o=1; reg_addr_o = latched addr - START_ADDR, truncated to AW bits. Payload is held stable until the handshake. The timeout counter increments each cycle.
    - On reg_ready_i=1 → RESP. Capture rdata = reg_rdata_i for reads, 0 for writes; err = reg_error_i.
    - If the counter reaches TIMEOUT_CYCLES with reg_ready_i still 0 → RESP with error; reg_valid_o drops.
    - reg_ready_i=1 in the same cycle as expiry counts as success; ready wins.
  - RESP: rvalid_o=1 for exactly one cycle, with rdata_o and resp_err_o. Then → IDLE. rdata_o returns to 0 after the response.
- gnt_o=0 in ISSUE and RESP, so at most one transaction is outstanding.
- Latency:
  - Miss: gnt at T, rvalid at T+1.
  - Hit with immediate ready: reg_valid at T+1, rvalid at T+2. Earliest next grant is T+3.
- Error data: on any error, reads return ERR_RDATA and writes return 0; resp_err_o=1. Writes on a miss or timeout have no downstream side effect.
- err_cnt_o: increments on every error response, in the RESP-entry cycle. Saturates at 255.
- Reset mid-transaction: abandons the transaction with no rvalid_o. reg_valid_o is low from the next edge. The downstream side must tolerate a dropped request.
- Unaligned addr_i: low 2 bits are forwarded unchanged in reg_addr_o; be_i is passed through without checking.

Decomposition:
- kronos_x_heep_pkg gains:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} kronos_resp_state_e
  - localparam KRONOS_ERR_RDATA = 32'hBADC_AB1E
- No sub-module: the FSM, window compare, timeout counter and error counter fit in one module of about 200 lines.

Test Plan:
- Bench uses START_ADDR=32'h0001_0000, WIN_SIZE=32'h1000, TIMEOUT_CYCLES=8.
- Read hit, zero-wait: req addr 0x0001_0040 at T, reg_ready_i=1 and reg_rdata_i=0xCAFE_0001 at T+1 → gnt T; reg_valid_o and reg_addr_o=0x040 at T+1; rvalid_o, rdata_o=0xCAFE_0001, resp_err_o=0 at T+2; err_cnt_o=0.
- Write hit, 3-cycle wait: write 0x0001_0FFC, wdata 0x1234_5678, be 4'b0011 → reg_addr_o=0xFFC and payload stable for 3 cycles until ready; rvalid with rdata_o=0 and resp_err_o=0.
- Boundary miss: read 0x0001_1000 and read 0x0000_FFFC → each gets rvalid at T+1 with rdata_o=0xBADC_AB1E and resp_err_o=1; reg_valid_o never asserted; err_cnt_o=2.
- Timeout: read hit with reg_ready_i held 0 → reg_valid_o high for 8 cycles, then drops; rvalid with 0xBADC_AB1E and resp_err_o=1. A repeat where ready arrives exactly at the expiry cycle is a success.
- Downstream error and saturation: reg_error_i=1 with ready → resp_err_o=1. Then 300 back-to-back misses → err_cnt_o stops at 255.
- Reset mid-ISSUE: assert rst_i for 1 cycle while reg_valid_o=1 → reg_valid_o=0 next cycle; no rvalid; all outputs at reset values; a new request right after reset completes normally.
